irq_ctrl_n: RTL and testbench

IRQ_CTRL_N -- requirements
Module: irq_ctrl_n

---
 rtl/irq_ctrl_n.sv | 96 +++++++++
 tb/tb_irq_ctrl_n.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_n.sv
// Interrupt controller: per-source edge/level capture, enable mask, W1C ack, overrun, priority ID.
// Latency: event -> Dr at the capturing en edge; IRQ/irqId one en edge later.
// Backpressure: none; all updates are gated by the en clock enable only.
//
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   en               - clock enable; registers hold when low
//   src              - raw active-high interrupt sources
//   enWr/modeWr/ackWr- write strobes for enable, mode, and W1C acknowledge (share Dw)
//   Dw               - write data
//   Dr               - pending status (registered)
//   ovr              - sticky overrun flags (registered)
//   IRQ              - registered OR of pending status
//   irqId            - registered index of lowest pending source
module irq_ctrl_n #(
    parameter int                NUM_SRC  = 8,
    parameter int                ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter logic [NUM_SRC-1:0] RST_MASK = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_SRC-1:0] src,
    input  logic               enWr,
    input  logic               modeWr,
    input  logic               ackWr,
    input  logic [NUM_SRC-1:0] Dw,
    output logic [NUM_SRC-1:0] Dr,
    output logic [NUM_SRC-1:0] ovr,
    output logic               IRQ,
    output logic [ID_W-1:0]    irqId
);

    logic [NUM_SRC-1:0] en_mask_q, en_mask_d;
    logic [NUM_SRC-1:0] mode_q,    mode_d;
    logic [NUM_SRC-1:0] src_q,     src_d;
    logic [NUM_SRC-1:0] status_q,  status_d;
    logic [NUM_SRC-1:0] ovr_q,     ovr_d;
    logic               irq_q,     irq_d;
    logic [ID_W-1:0]    irq_id_q,  irq_id_d;

    logic [NUM_SRC-1:0] event_vec;
    logic [NUM_SRC-1:0] eff_en;
    logic [NUM_SRC-1:0] ack_vec;

    // Level-mode bits pass src straight through; edge-mode bits need a 0->1 against the last sample.
    assign event_vec = (mode_q & src) | (~mode_q & src & ~src_q);

    // A same-cycle enable write takes effect immediately for capture and clearing.
    assign eff_en    = enWr ? Dw : en_mask_q;
    assign ack_vec   = ackWr ? Dw : '0;

    always_comb begin
        en_mask_d = enWr   ? Dw : en_mask_q;
        mode_d    = modeWr ? Dw : mode_q;
        src_d     = src;
        // Set beats ack: an event re-arms status even while being acknowledged.
        status_d  = eff_en & (event_vec | (status_q & ~ack_vec));
        // An ack always clears overrun, including when a new event lands in the same cycle.
        ovr_d     = eff_en & ~ack_vec & (ovr_q | (event_vec & status_q));
        // IRQ/irqId reflect status as it stood before this edge.
        irq_d     = |status_q;
        irq_id_d  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (status_q[i]) begin
                irq_id_d = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_mask_q <= RST_MASK;
            mode_q    <= '0;
            src_q     <= '0;
            status_q  <= '0;
            ovr_q     <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
        end else if (en) begin
            en_mask_q <= en_mask_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            status_q  <= status_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign Dr    = status_q;
    assign ovr   = ovr_q;
    assign IRQ   = irq_q;
    assign irqId = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Testbench for irq_ctrl_n: directed stimulus, per-source reference model, literal spot checks.
// Latency: inputs change 1 time unit after posedge; outputs compared at negedge and after each tick.
// Backpressure: not applicable.
module tb_irq_ctrl_n;

    localparam int         N    = 8;
    localparam int         IDW  = 3;
    localparam logic [7:0] RMSK = 8'h80;

    logic           clk;
    logic           reset;
    logic           en;
    logic [N-1:0]   src;
    logic           enWr;
    logic           modeWr;
    logic           ackWr;
    logic [N-1:0]   Dw;
    logic [N-1:0]   Dr;
    logic [N-1:0]   ovr;
    logic           IRQ;
    logic [IDW-1:0] irqId;

    int vectors = 0;
    int misses  = 0;

    irq_ctrl_n #(
        .NUM_SRC (N),
        .ID_W    (IDW),
        .RST_MASK(RMSK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .src   (src),
        .enWr  (enWr),
        .modeWr(modeWr),
        .ackWr (ackWr),
        .Dw    (Dw),
        .Dr    (Dr),
        .ovr   (ovr),
        .IRQ   (IRQ),
        .irqId (irqId)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each source tracked independently from the behavioural rules.
    bit       m_valid = 1'b0;
    bit       m_en   [N];
    bit       m_mode [N];
    bit       m_srcq [N];
    bit       m_stat [N];
    bit       m_ovr  [N];
    bit       m_irq;
    int       m_id;
    bit       ev, on_b, ak, any_p;
    int       first_p;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_en[i]   = RMSK[i];
                m_mode[i] = 1'b0;
                m_srcq[i] = 1'b0;
                m_stat[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end
            m_irq   = 1'b0;
            m_id    = 0;
            m_valid = 1'b1;
        end else if (en) begin
            any_p   = 1'b0;
            first_p = 0;
            for (int i = 0; i < N; i++) begin
                if (m_stat[i] && !any_p) begin
                    any_p   = 1'b1;
                    first_p = i;
                end
            end
            for (int i = 0; i < N; i++) begin
                ev   = m_mode[i] ? src[i] : (src[i] && !m_srcq[i]);
                on_b = enWr ? Dw[i] : m_en[i];
                ak   = ackWr && Dw[i];
                if (!on_b) begin
                    m_stat[i] = 1'b0;
                    m_ovr[i]  = 1'b0;
                end else if (ev) begin
                    if (ak)             m_ovr[i] = 1'b0;
                    else if (m_stat[i]) m_ovr[i] = 1'b1;
                    m_stat[i] = 1'b1;
                end else if (ak) begin
                    m_stat[i] = 1'b0;
                    m_ovr[i]  = 1'b0;
                end
                if (enWr)   m_en[i]   = Dw[i];
                if (modeWr) m_mode[i] = Dw[i];
                m_srcq[i] = src[i];
            end
            m_irq = any_p;
            m_id  = first_p;
        end
    end

    function automatic logic [N-1:0] pack_stat();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_stat[i];
        return v;
    endfunction

    function automatic logic [N-1:0] pack_ovr();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ovr[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_Dr",    32'(Dr),    32'(pack_stat()));
            chk("model_ovr",   32'(ovr),   32'(pack_ovr()));
            chk("model_IRQ",   32'(IRQ),   32'(m_irq));
            chk("model_irqId", 32'(irqId), 32'(m_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enWr   = 1'b0;
        modeWr = 1'b0;
        ackWr  = 1'b0;
        Dw     = '0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        src   = '0;
        idle();
        tick();
        tick();
        chk("rst_Dr",    32'(Dr),    32'h0);
        chk("rst_ovr",   32'(ovr),   32'h0);
        chk("rst_IRQ",   32'(IRQ),   32'h0);
        chk("rst_irqId", 32'(irqId), 32'h0);

        // Source 7 is enabled by RST_MASK and already high as reset releases.
        src = 8'h80;
        tick();
        reset = 1'b0;
        tick();
        chk("rstmask_edge_Dr", 32'(Dr), 32'h80);
        src = 8'hC0;                         // bit 6 disabled, bit 7 no new edge
        tick();
        chk("disabled_src6_Dr", 32'(Dr), 32'h80);
        chk("disabled_src6_ovr", 32'(ovr), 32'h0);
        src = 8'h00; ackWr = 1'b1; Dw = 8'h80;
        tick();
        chk("ack7_Dr", 32'(Dr), 32'h0);
        chk("ack7_IRQ", 32'(IRQ), 32'h1);
        chk("ack7_irqId", 32'(irqId), 32'h7);
        idle();
        tick();
        chk("ack7_IRQ_fall", 32'(IRQ), 32'h0);

        // Edge path on source 0.
        enWr = 1'b1; Dw = 8'h01;
        tick();
        idle();
        src = 8'h01;
        tick();
        chk("edge_Dr", 32'(Dr), 32'h01);
        chk("edge_IRQ_not_yet", 32'(IRQ), 32'h0);
        src = 8'h00;
        tick();
        chk("edge_IRQ", 32'(IRQ), 32'h1);
        chk("edge_irqId", 32'(irqId), 32'h0);
        ackWr = 1'b1; Dw = 8'h01;
        tick();
        idle();
        chk("edge_ack_Dr", 32'(Dr), 32'h00);
        tick();
        chk("edge_ack_IRQ", 32'(IRQ), 32'h0);

        // Overrun on source 6.
        enWr = 1'b1; Dw = 8'h40;
        tick();
        idle();
        src = 8'h40; tick();
        src = 8'h00; tick();
        src = 8'h40; tick();
        chk("ovr_set_ovr", 32'(ovr), 32'h40);
        chk("ovr_set_Dr", 32'(Dr), 32'h40);
        src = 8'h00; ackWr = 1'b1; Dw = 8'h40;
        tick();
        idle();
        chk("ovr_ack_ovr", 32'(ovr), 32'h00);
        chk("ovr_ack_Dr", 32'(Dr), 32'h00);

        // Level mode on source 3, acknowledged every cycle while held high.
        modeWr = 1'b1; enWr = 1'b1; Dw = 8'h08;
        tick();
        idle();
        src = 8'h08; ackWr = 1'b1; Dw = 8'h08;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("level_hold_Dr", 32'(Dr), 32'h08);
        end
        chk("level_hold_IRQ", 32'(IRQ), 32'h1);
        chk("level_hold_ovr", 32'(ovr), 32'h00);
        src = 8'h00;
        tick();
        chk("level_release_Dr", 32'(Dr), 32'h00);
        idle();
        modeWr = 1'b1; Dw = 8'h00;
        tick();
        idle();

        // Disable clears pending and overrun for bits written 0.
        enWr = 1'b1; Dw = 8'h06;
        tick();
        idle();
        src = 8'h02; tick();
        src = 8'h00; tick();
        src = 8'h06; tick();
        chk("dis_pre_Dr", 32'(Dr), 32'h06);
        chk("dis_pre_ovr", 32'(ovr), 32'h02);
        src = 8'h00; enWr = 1'b1; Dw = 8'h04;
        tick();
        idle();
        chk("dis_Dr", 32'(Dr), 32'h04);
        chk("dis_ovr", 32'(ovr), 32'h00);
        src = 8'h02; tick();
        src = 8'h00; tick();
        chk("dis_src1_ignored", 32'(Dr), 32'h04);

        // Priority encoding with sources 4 and 7 pending.
        ackWr = 1'b1; enWr = 1'b1; Dw = 8'h90;
        tick();
        idle();
        src = 8'h90; tick();
        chk("prio_Dr", 32'(Dr), 32'h90);
        src = 8'h00; tick();
        chk("prio_irqId4", 32'(irqId), 32'h4);
        ackWr = 1'b1; Dw = 8'h10;
        tick();
        idle();
        chk("prio_ack_Dr", 32'(Dr), 32'h80);
        tick();
        chk("prio_irqId7", 32'(irqId), 32'h7);

        // Clock enable low: edges and strobes are ignored.
        en = 1'b0;
        enWr = 1'b1; modeWr = 1'b1; ackWr = 1'b1; Dw = 8'hFF;
        src = 8'h01; tick();
        src = 8'h00; tick();
        src = 8'hFF; tick();
        chk("en0_Dr", 32'(Dr), 32'h80);
        chk("en0_ovr", 32'(ovr), 32'h00);
        chk("en0_IRQ", 32'(IRQ), 32'h1);
        chk("en0_irqId", 32'(irqId), 32'h7);

        // Reset while pending and with en low.
        reset = 1'b1;
        tick();
        chk("rst2_Dr", 32'(Dr), 32'h00);
        chk("rst2_ovr", 32'(ovr), 32'h00);
        chk("rst2_IRQ", 32'(IRQ), 32'h0);
        chk("rst2_irqId", 32'(irqId), 32'h0);
        reset = 1'b0;
        en = 1'b1;
        idle();
        src = 8'h81;
        tick();
        chk("rst2_mask_Dr", 32'(Dr), 32'h80);
        src = 8'h00;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
